// File: rtl/asic_fptd_shell.sv
// asic_fptd_shell: 104-bit-frame turbo-decoder test-chip shell.
// Optional build macro FRAME_READBACK_EN: lane-6 readback on bitout2.
module asic_fptd_shell #(
    parameter int FL        = 104,
    parameter int N         = 4,
    parameter int LANES     = 7,
    parameter int LANE_BITS = 200,
    parameter int DCMAX     = 200
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Mode,
    input  logic             Go,
    input  logic             Enable_f,
    input  logic             Sel_f,
    input  logic             S1,
    input  logic             S2,
    input  logic             S3,
    input  logic [LANES-1:0] In,
    output logic [6:0]       DOut1,
    output logic [6:0]       DOut2,
    output logic [6:0]       TOut,
    output logic             bitout1,
    output logic             bitout2,
    output logic             KeepShift,
    output logic             Start,
    output logic             Start2,
    output logic             TestReady,
    output logic             Dclk
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_LLRS  = 3'd1,
        DECODE     = 3'd2,
        EARLY_STOP = 3'd3,
        MAX_DCS    = 3'd4,
        FINISH     = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic   arm_q;
    logic [1:0] div_q, div_d, div_max;
    logic [7:0] cap_q, cap_d;
    logic [7:0] dc_q, dc_d;
    logic [6:0] err_q, err_d;
    logic [6:0] tout_q, tout_d;
    logic       cap;

    // Lanes 0, 1 and 5 carry LLRs the hard-decision path never reads,
    // so only the lanes holding bua3 and the reference bits are kept.
    // Lane 4 needs just its last 56 arrivals (bua3[90..103]).
    logic [LANE_BITS-1:0] lane2_q, lane3_q, lane6_q;
    logic [55:0]          lane4_q;
    logic [LANES-1:0]     lb1_q, lb2_q;

    logic [FL*N-1:0] bua3;
    logic [6:0]      k;
    logic [N-1:0]    llr;
    logic            bref, dbit;

    assign bua3    = {lane4_q, lane3_q, lane2_q[LANE_BITS-1:40]};
    assign k       = (dc_q < 8'(FL)) ? dc_q[6:0] : 7'd0;
    assign llr     = bua3[{k, 2'b00} +: N];
    assign bref    = lane6_q[8'd96 + {1'b0, k}];
    assign dbit    = llr[N-1];
    assign div_max = Enable_f ? (Sel_f ? 2'd1 : 2'd3) : 2'd0;
    assign Start2  = Start;
    assign Dclk    = cap;
    assign TOut    = tout_q;

    // Frame sequencer: next state, counters and strobes
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cap_d     = cap_q;
        dc_d      = dc_q;
        err_d     = err_q;
        tout_d    = tout_q;
        cap       = 1'b0;
        Start     = 1'b0;
        TestReady = 1'b0;
        KeepShift = 1'b0;
        bitout1   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Go && arm_q) begin
                    Start   = 1'b1;
                    cap     = 1'b1;
                    cap_d   = 8'd1;
                    div_d   = 2'd0;
                    dc_d    = 8'd0;
                    err_d   = 7'd0;
                    state_d = LOAD_LLRS;
                end
            end
            LOAD_LLRS: begin
                KeepShift = 1'b1;
                if (cap_q == 8'(LANE_BITS)) begin
                    state_d = DECODE;
                end else if (div_q >= div_max) begin
                    cap   = 1'b1;
                    div_d = 2'd0;
                    cap_d = cap_q + 8'd1;
                end else begin
                    div_d = div_q + 2'd1;
                end
            end
            DECODE: begin
                bitout1 = dbit;
                if (dc_q != 8'(DCMAX - 1)) dc_d = dc_q + 8'd1;
                if (dbit != bref && err_q != 7'h7f) err_d = err_q + 7'd1;
                if (dc_q == 8'(FL - 1))
                    state_d = (err_d == 7'd0) ? EARLY_STOP : MAX_DCS;
            end
            EARLY_STOP, MAX_DCS: state_d = FINISH;
            FINISH: begin
                TestReady = 1'b1;
                tout_d    = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and counters
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
            div_q   <= '0;
            cap_q   <= '0;
            dc_q    <= '0;
            err_q   <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            div_q   <= div_d;
            cap_q   <= cap_d;
            dc_q    <= dc_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    // Lane capture: first-arriving bit ends at the MSB
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            lane2_q <= '0;
            lane3_q <= '0;
            lane4_q <= '0;
            lane6_q <= '0;
        end else if (cap) begin
            lane2_q <= {lane2_q[LANE_BITS-2:0], In[2]};
            lane3_q <= {lane3_q[LANE_BITS-2:0], In[3]};
            lane4_q <= {lane4_q[54:0], In[4]};
            lane6_q <= {lane6_q[LANE_BITS-2:0], In[6]};
        end
    end

    // Loopback registers for the tester pin check
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            lb1_q <= '0;
            lb2_q <= '0;
        end else begin
            lb1_q <= In;
            lb2_q <= ~In;
        end
    end

    // Debug output select
    always_comb begin
        DOut1 = '0;
        DOut2 = '0;
        if (!Mode) begin
            DOut1 = lb1_q;
            DOut2 = lb2_q;
        end else begin
            unique case ({S3, S2, S1})
                3'b000: begin
                    DOut1 = dc_q[6:0];
                    DOut2 = {4'b0, state_q};
                end
                3'b001: begin
                    DOut1 = err_q;
                    DOut2 = {3'b0, llr};
                end
                default: ;
            endcase
        end
    end

`ifdef FRAME_READBACK_EN
    logic [7:0] rb_q;

    // Readback pointer walks lane 6 from MSB down, wrapping
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            rb_q <= 8'(LANE_BITS - 1);
        else if (state_q != DECODE)
            rb_q <= 8'(LANE_BITS - 1);
        else
            rb_q <= (rb_q == 8'd0) ? 8'(LANE_BITS - 1) : rb_q - 8'd1;
    end

    assign bitout2 = (state_q == DECODE) && lane6_q[rb_q];
`else
    assign bitout2 = 1'b0;
`endif

endmodule

// File: tb/tb_asic_fptd_shell.sv
// tb_asic_fptd_shell: directed checks for asic_fptd_shell.
// Frames are fed serially from per-lane bit images.
module tb_asic_fptd_shell;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       Mode = 1'b1;
    logic       Go = 1'b0;
    logic       Enable_f = 1'b0;
    logic       Sel_f = 1'b0;
    logic       S1 = 1'b0;
    logic       S2 = 1'b0;
    logic       S3 = 1'b0;
    logic [6:0] In = '0;
    logic [6:0] DOut1, DOut2, TOut;
    logic       bitout1, bitout2, KeepShift;
    logic       Start, Start2, TestReady, Dclk;

    int n_run = 0;
    int n_fail = 0;

    logic [199:0] lanes [7];

    int n_start, n_dclk, dclk_first, dclk_last, n_keep, n_dec;
    int n_tr, tr_at, b2_hi, s2_bad;
    bit saw_es, saw_mx;
    logic [127:0] dec_bits;

    asic_fptd_shell dut (
        .Clock(Clock), .nReset(nReset), .Mode(Mode), .Go(Go),
        .Enable_f(Enable_f), .Sel_f(Sel_f),
        .S1(S1), .S2(S2), .S3(S3), .In(In),
        .DOut1(DOut1), .DOut2(DOut2), .TOut(TOut),
        .bitout1(bitout1), .bitout2(bitout2),
        .KeepShift(KeepShift), .Start(Start), .Start2(Start2),
        .TestReady(TestReady), .Dclk(Dclk)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_base();
        for (int l = 0; l < 7; l++)
            for (int j = 0; j < 50; j++)
                lanes[l][4*j +: 4] = 4'h1;
        lanes[6][199:96] = '0;
    endtask

    task automatic put_bua3(input int kk, input logic [3:0] v);
        if (kk < 40)      lanes[2][40 + 4*kk +: 4] = v;
        else if (kk < 90) lanes[3][4*(kk-40) +: 4] = v;
        else              lanes[4][4*(kk-90) +: 4] = v;
    endtask

    task automatic run_frame(input logic ef, input logic sf);
        int ptr;
        ptr = 199;
        n_start = 0; n_dclk = 0; dclk_first = -1; dclk_last = -1;
        n_keep = 0; n_dec = 0; n_tr = 0; tr_at = -1;
        b2_hi = 0; s2_bad = 0; saw_es = 0; saw_mx = 0;
        dec_bits = '0;
        Enable_f = ef; Sel_f = sf;
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clock);
            Go = (n_start == 0);
            for (int l = 0; l < 7; l++)
                In[l] = (ptr >= 0) ? lanes[l][ptr] : 1'b0;
            #1;
            if (Start) n_start++;
            if (Start !== Start2) s2_bad++;
            if (Dclk) begin
                n_dclk++;
                if (dclk_first < 0) dclk_first = c;
                dclk_last = c;
                ptr--;
            end
            if (KeepShift) n_keep++;
            if (bitout2) b2_hi++;
            if (DOut2[2:0] == 3'd2) begin
                if (n_dec < 128) dec_bits[n_dec] = bitout1;
                n_dec++;
            end
            if (DOut2[2:0] == 3'd3) saw_es = 1;
            if (DOut2[2:0] == 3'd4) saw_mx = 1;
            if (TestReady) begin
                n_tr++;
                if (tr_at < 0) tr_at = c;
            end
            if (tr_at >= 0 && c == tr_at + 5) break;
        end
        chk("frame_timeout", 128'(tr_at >= 0), 128'd1);
        Go = 0;
    endtask

    initial begin
        int got;
        // reset state
        Go = 1;
        repeat (3) @(negedge Clock);
        #1;
        chk("rst_start", Start, 0);
        chk("rst_dclk", Dclk, 0);
        chk("rst_keep", KeepShift, 0);
        chk("rst_tr", TestReady, 0);
        chk("rst_dout1", DOut1, 0);
        chk("rst_dout2", DOut2, 0);
        chk("rst_tout", TOut, 0);
        chk("rst_bit1", bitout1, 0);
        chk("rst_bit2", bitout2, 0);
        Go = 0;
        @(negedge Clock);
        nReset = 1;

        // idle with Go low
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            #1;
            chk("idle_start", Start, 0);
            chk("idle_tout", TOut, 0);
            chk("idle_state", DOut2, 0);
        end

        // loopback mode
        @(negedge Clock);
        Mode = 0; In = 7'h55;
        @(negedge Clock);
        #1;
        chk("lb_d1_a", DOut1, 7'h55);
        chk("lb_d2_a", DOut2, 7'h2a);
        In = 7'h0c;
        @(negedge Clock);
        #1;
        chk("lb_d1_b", DOut1, 7'h0c);
        chk("lb_d2_b", DOut2, 7'h73);
        Mode = 1; In = '0;

        // frame A: all +1, reference 0
        fill_base();
        run_frame(0, 0);
        chk("A_start", n_start, 1);
        chk("A_start2", s2_bad, 0);
        chk("A_dclk", n_dclk, 200);
        chk("A_dclk_run", dclk_last - dclk_first, 199);
        chk("A_keep", n_keep, 200);
        chk("A_dec", n_dec, 104);
        chk("A_es", saw_es, 1);
        chk("A_mx", saw_mx, 0);
        chk("A_tr", n_tr, 1);
        chk("A_tout", TOut, 0);
        chk("A_bits", dec_bits, 0);
        chk("A_bit2", b2_hi, 0);
        chk("A_dc", DOut1, 7'd104);
        S2 = 1;
        #1;
        chk("A_sel010_d1", DOut1, 0);
        chk("A_sel010_d2", DOut2, 0);
        S2 = 0;

        // frame B: bua3[0..9] = -1
        fill_base();
        for (int i = 0; i < 10; i++) put_bua3(i, 4'hf);
        run_frame(0, 0);
        chk("B_mx", saw_mx, 1);
        chk("B_es", saw_es, 0);
        chk("B_tout", TOut, 10);
        chk("B_bits", dec_bits, 128'h3ff);
        chk("B_dec", n_dec, 104);
        S1 = 1;
        #1;
        chk("B_err_live", DOut1, 10);
        chk("B_llr0", DOut2, 7'h0f);
        S1 = 0;

        // reset during LOAD_LLRS
        fill_base();
        Enable_f = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            Go = 1;
            #1;
            if (KeepShift) got++;
        end
        chk("R_loading", 128'(got > 0), 128'd1);
        @(negedge Clock);
        nReset = 0;
        #1;
        chk("R_keep", KeepShift, 0);
        chk("R_dclk", Dclk, 0);
        chk("R_start", Start, 0);
        chk("R_tout", TOut, 0);
        chk("R_dout1", DOut1, 0);
        chk("R_dout2", DOut2, 0);
        @(negedge Clock);
        nReset = 1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            if (got > 0) Go = 0;
            #1;
            if (Start) got++;
        end
        chk("R_fresh_start", got, 1);
        @(negedge Clock);
        Go = 0; nReset = 0;
        @(negedge Clock);
        nReset = 1;

        // frame E: every bua3 negative, reference all ones
        fill_base();
        for (int i = 0; i < 104; i++) put_bua3(i, 4'h9);
        lanes[6][199:96] = '1;
        run_frame(0, 0);
        chk("E_es", saw_es, 1);
        chk("E_mx", saw_mx, 0);
        chk("E_tout", TOut, 0);
        chk("E_bits", dec_bits, (128'd1 << 104) - 128'd1);

        // frame C: divide by 4
        fill_base();
        run_frame(1, 0);
        chk("C_dclk", n_dclk, 200);
        chk("C_span", dclk_last - dclk_first, 796);
        chk("C_keep", n_keep, 797);
        chk("C_es", saw_es, 1);
        chk("C_dec", n_dec, 104);

        // frame D: divide by 2
        fill_base();
        put_bua3(103, 4'h8);
        run_frame(1, 1);
        chk("D_dclk", n_dclk, 200);
        chk("D_span", dclk_last - dclk_first, 398);
        chk("D_keep", n_keep, 399);
        chk("D_tout", TOut, 1);
        chk("D_bits", dec_bits, 128'd1 << 103);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
